// File: rtl/pixel_compositor.sv
// Final-stage VGA pixel compositor: colour-key transparency, per-player
// hurt blink, and a scene-change fade (black hold followed by a stepped
// fade-in). All colour outputs are registered with one clock of latency.
module pixel_compositor #(
  parameter logic [11:0] KEY_COLOR    = 12'hF0F,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter int unsigned BLINK_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES  = 8,
  parameter int unsigned STEP_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        vsync,
  input  logic [11:0] pixel_in,
  input  logic        show_pixel,
  input  logic        is_char,
  input  logic        is_char_1,
  input  logic        hurt,
  input  logic        hurt_1,
  input  logic [3:0]  scene,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        fade_busy
);

  localparam int unsigned FMAX = (HOLD_FRAMES > STEP_FRAMES) ? HOLD_FRAMES : STEP_FRAMES;
  localparam int unsigned FCW  = (FMAX > 1) ? $clog2(FMAX) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, FADE_IN} fade_state_t;

  fade_state_t    state;
  logic [4:0]     level;
  logic [FCW-1:0] frame_cnt;
  logic [3:0]     scene_q;
  logic           vsync_q;
  logic           frame_tick;
  logic [5:0]     blink_0;
  logic [5:0]     blink_1;
  logic           hidden;
  logic [11:0]    base;

  // Scale one 4-bit channel by level/16; level 16 is an exact pass-through.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
    logic [8:0] p;
    p = 9'(c) * 9'(lvl);
    return 4'(p >> 4);
  endfunction

  // Registered copy of vsync for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vsync_q <= 1'b0;
    else     vsync_q <= vsync;
  end

  assign frame_tick = vsync & ~vsync_q;

  // Per-player blink counters: hurt reloads (and beats a same-cycle tick),
  // otherwise one decrement per frame, saturating at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_0 <= '0;
      blink_1 <= '0;
    end else begin
      if (hurt)                           blink_0 <= 6'(BLINK_FRAMES);
      else if (frame_tick && blink_0 != '0) blink_0 <= blink_0 - 6'd1;
      if (hurt_1)                         blink_1 <= 6'(BLINK_FRAMES);
      else if (frame_tick && blink_1 != '0) blink_1 <= blink_1 - 6'd1;
    end
  end

  // Blink hiding; player 0 decides when a pixel is tagged for both players.
  always_comb begin
    hidden = 1'b0;
    if (is_char)        hidden = (blink_0 != '0) && blink_0[2];
    else if (is_char_1) hidden = (blink_1 != '0) && blink_1[2];
  end

  // Base colour selection in priority order.
  always_comb begin
    base = pixel_in;
    if (!valid)                     base = 12'h000;
    else if (!show_pixel)           base = BG_COLOR;
    else if (pixel_in == KEY_COLOR) base = BG_COLOR;
    else if (hidden)                base = BG_COLOR;
  end

  // Output register: base colour scaled by the current fade level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      vga_r <= scale(base[11:8], level);
      vga_g <= scale(base[7:4],  level);
      vga_b <= scale(base[3:0],  level);
    end
  end

  // Fade FSM: any scene change restarts from black; HOLD counts frames,
  // FADE_IN raises level by 2 every STEP_FRAMES frames until full scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      level     <= 5'd16;
      frame_cnt <= '0;
      scene_q   <= 4'h0;
    end else begin
      scene_q <= scene;
      if (scene != scene_q) begin
        state     <= HOLD;
        level     <= '0;
        frame_cnt <= '0;
      end else begin
        case (state)
          IDLE: level <= 5'd16;
          HOLD: begin
            if (frame_tick) begin
              if (frame_cnt == FCW'(HOLD_FRAMES - 1)) begin
                state     <= FADE_IN;
                frame_cnt <= '0;
              end else begin
                frame_cnt <= frame_cnt + FCW'(1);
              end
            end
          end
          FADE_IN: begin
            if (frame_tick) begin
              if (frame_cnt == FCW'(STEP_FRAMES - 1)) begin
                frame_cnt <= '0;
                if (level >= 5'd14) begin
                  level <= 5'd16;
                  state <= IDLE;
                end else begin
                  level <= level + 5'd2;
                end
              end else begin
                frame_cnt <= frame_cnt + FCW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign fade_busy = (state != IDLE);

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor: a frame-count based reference
// model predicts every output, plus directed literal checks.
module tb_pixel_compositor;

  localparam logic [11:0] KEY   = 12'hF0F;
  localparam logic [11:0] BG    = 12'h123;
  localparam int          BLINK = 60;
  localparam int          HOLDF = 8;
  localparam int          STEPF = 2;

  logic        clk, rst, valid, vsync, show_pixel, is_char, is_char_1, hurt, hurt_1;
  logic [11:0] pixel_in;
  logic [3:0]  scene;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        fade_busy;

  int total = 0;
  int bad   = 0;

  // Model state: ticks since last hurt per player, ticks since last scene change.
  int   since0, since1, n_ticks;
  bit   active;
  logic vs_prev;
  logic [3:0] scene_prev;

  pixel_compositor #(
    .KEY_COLOR(KEY), .BG_COLOR(BG), .BLINK_FRAMES(BLINK),
    .HOLD_FRAMES(HOLDF), .STEP_FRAMES(STEPF)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .vsync(vsync), .pixel_in(pixel_in),
    .show_pixel(show_pixel), .is_char(is_char), .is_char_1(is_char_1),
    .hurt(hurt), .hurt_1(hurt_1), .scene(scene),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .fade_busy(fade_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int blink_of(input int since);
    return (since >= BLINK) ? 0 : BLINK - since;
  endfunction

  function automatic int model_level();
    int k;
    if (!active) return 16;
    if (n_ticks < HOLDF) return 0;
    k = 2 * ((n_ticks - HOLDF) / STEPF);
    return (k > 16) ? 16 : k;
  endfunction

  function automatic bit model_busy();
    return active && (n_ticks < HOLDF + 8 * STEPF);
  endfunction

  function automatic logic [11:0] model_rgb();
    logic [11:0] b;
    bit hid;
    int lv;
    hid = 0;
    if (is_char)        hid = (blink_of(since0) & 4) != 0;
    else if (is_char_1) hid = (blink_of(since1) & 4) != 0;
    if (!valid)                b = 12'h000;
    else if (!show_pixel)      b = BG;
    else if (pixel_in == KEY)  b = BG;
    else if (hid)              b = BG;
    else                       b = pixel_in;
    lv = model_level();
    return {4'((int'(b[11:8]) * lv) / 16), 4'((int'(b[7:4]) * lv) / 16),
            4'((int'(b[3:0]) * lv) / 16)};
  endfunction

  task automatic model_reset();
    since0 = 1000; since1 = 1000; n_ticks = 0; active = 0;
    vs_prev = 1'b0; scene_prev = 4'h0;
  endtask

  task automatic model_update();
    bit tick;
    tick = vsync && !vs_prev;
    vs_prev = vsync;
    if (hurt) since0 = 0; else if (tick && since0 < 1000) since0++;
    if (hurt_1) since1 = 0; else if (tick && since1 < 1000) since1++;
    if (scene != scene_prev) begin
      active = 1; n_ticks = 0;
    end else if (tick && active && n_ticks < 10000) n_ticks++;
    scene_prev = scene;
  endtask

  // One clock: predict from pre-edge state and inputs, compare after the edge.
  task automatic cycle();
    logic [11:0] e;
    e = model_rgb();
    @(posedge clk);
    #1;
    model_update();
    check("rgb", {vga_r, vga_g, vga_b}, e);
    check("fade_busy", {11'b0, fade_busy}, {11'b0, model_busy()});
  endtask

  task automatic frames(input int n, input int len);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < len; c++) begin
        vsync = (c < 2);
        cycle();
      end
    end
    vsync = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 0; vsync = 0; show_pixel = 0; is_char = 0; is_char_1 = 0;
    hurt = 0; hurt_1 = 0; scene = 4'h0; pixel_in = 12'h000;
    model_reset();
    #12;
    check("reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("reset_busy", {11'b0, fade_busy}, 12'h000);
    rst = 1'b0;
    cycle();

    // Base colour priority in IDLE at full level.
    valid = 1; show_pixel = 1; pixel_in = 12'h5A3; cycle();
    check("pix_5a3", {vga_r, vga_g, vga_b}, 12'h5A3);
    pixel_in = KEY; cycle();
    check("key_bg", {vga_r, vga_g, vga_b}, BG);
    show_pixel = 0; pixel_in = 12'hFFF; cycle();
    check("noshow_bg", {vga_r, vga_g, vga_b}, BG);
    valid = 0; cycle();
    check("invalid_black", {vga_r, vga_g, vga_b}, 12'h000);

    // Scene 0->1 then 1->4 fade.
    valid = 1; show_pixel = 1; pixel_in = 12'hFFF;
    scene = 4'h1; cycle();
    check("busy_after_change", {11'b0, fade_busy}, 12'h001);
    frames(HOLDF + 8 * STEPF, 6);
    check("idle_again", {11'b0, fade_busy}, 12'h000);
    scene = 4'h4; cycle();
    check("busy_1_to_4", {11'b0, fade_busy}, 12'h001);
    frames(HOLDF - 1, 6); cycle();
    check("hold_black", {vga_r, vga_g, vga_b}, 12'h000);
    frames(9, 6); cycle();
    check("level8", {vga_r, vga_g, vga_b}, 12'h777);
    frames(8, 6); cycle();
    check("fade_done_busy", {11'b0, fade_busy}, 12'h000);
    check("fade_done_rgb", {vga_r, vga_g, vga_b}, 12'hFFF);

    // Change mid-FADE_IN at level 10 restarts the full hold.
    scene = 4'h7; cycle();
    frames(HOLDF + 5 * STEPF, 6);
    scene = 4'h9; cycle();
    check("restart_busy", {11'b0, fade_busy}, 12'h001);
    frames(HOLDF - 1, 6); cycle();
    check("restart_hold", {vga_r, vga_g, vga_b}, 12'h000);
    frames(1 + STEPF, 6); cycle();
    check("restart_lvl2", {vga_r, vga_g, vga_b}, 12'h111);
    frames(14, 6);

    // Blink for player 0.
    is_char = 1; pixel_in = 12'h0F0;
    hurt = 1; cycle(); hurt = 0; cycle();
    check("blink_60_hidden", {vga_r, vga_g, vga_b}, BG);
    frames(40, 5);
    vsync = 1; hurt = 1; cycle(); hurt = 0; cycle(); vsync = 0; cycle();
    check("hurt_wins_tick", {vga_r, vga_g, vga_b}, BG);
    frames(BLINK, 5); cycle();
    check("blink_over", {vga_r, vga_g, vga_b}, 12'h0F0);
    hurt_1 = 1; cycle(); hurt_1 = 0; cycle();
    check("hurt1_no_effect", {vga_r, vga_g, vga_b}, 12'h0F0);

    // Asynchronous reset mid-HOLD.
    scene = 4'h2; cycle();
    frames(3, 6);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {11'b0, fade_busy}, 12'h000);
    check("async_rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    check("rst_then_change", {11'b0, fade_busy}, 12'h001);

    // Randomized traffic against the model.
    for (int f = 0; f < 250; f++) begin
      int len;
      len = $urandom_range(20, 8);
      for (int c = 0; c < len; c++) begin
        vsync      = (c < 2);
        valid      = ($urandom_range(7) != 0);
        show_pixel = ($urandom_range(5) != 0);
        pixel_in   = ($urandom_range(7) == 0) ? KEY : 12'($urandom);
        is_char    = ($urandom_range(2) == 0);
        is_char_1  = ($urandom_range(2) == 0);
        hurt       = ($urandom_range(40) == 0);
        hurt_1     = ($urandom_range(40) == 0);
        if ($urandom_range(300) == 0) scene = 4'($urandom);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
